// File: rtl/configurable_receiver.sv
// Configurable UART receiver: 2-flop input synchronizer, mid-bit sampling,
// optional odd/even parity, one or two stop bits, and a BREAK state so that a
// line held low after a bad stop bit reports only one frame.
module configurable_receiver #(
  parameter int unsigned CLOCKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT + 1);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  // The counter holds j-1 in the j-th cycle after the state was entered, so
  // comparing against (n-1) lands the sample exactly n cycles after entry.
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StDone   = 3'd5,
    StBreak  = 3'd6
  } state_e;

  state_e               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_frame_fe;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_parity_error;
  logic                 r_framing_error;

  logic w_s;
  logic w_bit_end;
  logic w_par_err;

  assign w_s       = r_sync2;
  assign w_bit_end = (r_cnt == FULL_M1);
  assign w_par_err = (PARITY != 0) && (((^r_shift) ^ r_par_bit) != PAR_ODD);

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM with bit timing, shift register and registered frame outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_par_bit       <= 1'b0;
      r_frame_fe      <= 1'b0;
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (!w_s) begin
            r_state <= StStart;
            r_cnt   <= '0;
            r_idx   <= '0;
          end
        end
        StStart: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (w_s) begin
              r_state <= StIdle;
            end else begin
              r_state    <= StData;
              r_frame_fe <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_s;
            if (r_idx == LAST_DATA) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? StParity : StStop;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_bit <= w_s;
            r_state   <= StStop;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StStop: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (!w_s) begin
              r_frame_fe <= 1'b1;
            end
            if (r_idx == LAST_STOP) begin
              r_idx   <= '0;
              r_state <= StDone;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StDone: begin
          r_rx_valid      <= 1'b1;
          r_rx_data       <= r_shift;
          r_parity_error  <= w_par_err;
          r_framing_error <= r_frame_fe;
          r_state         <= r_frame_fe ? StBreak : StIdle;
        end
        StBreak: begin
          // Wait for the line to recover so a stuck-low line reports once.
          if (w_s) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign parity_error  = r_parity_error;
  assign framing_error = r_framing_error;
  assign busy          = (r_state != StIdle);

endmodule
